// File: rtl/lbm_rng_pkg.sv
// Shared definitions for the LBM pseudo-random word generator: word type, feedback taps
// and the generator FSM state type.
package lbm_rng_pkg;

  localparam int LFSR_W = 25;

  typedef logic signed [LFSR_W-1:0] rnd_word_t;

  localparam int TAP_HI = 24;
  localparam int TAP_LO = 21;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 25'h1ACE5B1;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } rng_state_t;

endpackage

// File: rtl/lfsr25_step.sv
// One Fibonacci step of the x^25 + x^22 + 1 LFSR; purely combinational so it can be
// chained later for skip-ahead.
module lfsr25_step
  import lbm_rng_pkg::*;
(
  input  logic [LFSR_W-1:0] state_i,
  output logic [LFSR_W-1:0] next_o
);

  assign next_o = {state_i[LFSR_W-2:0], state_i[TAP_HI] ^ state_i[TAP_LO]};

endmodule

// File: rtl/lfsr25_gen.sv
// 25-bit maximal-length LFSR word source with seed load, zero-seed substitution,
// post-seed warm-up discard, lock-up recovery and a registered valid/ready output.
module lfsr25_gen #(
  parameter logic [24:0] DEFAULT_SEED  = lbm_rng_pkg::DEFAULT_SEED,
  parameter int          WARMUP_CYCLES = 32,
  parameter int          CNT_W         = 6
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               seed_load,
  input  logic [24:0]        seed,
  input  logic               enable,
  output logic signed [24:0] rnd_out,
  output logic               rnd_valid,
  input  logic               rnd_ready,
  output logic               warming,
  output logic               lockup
);

  import lbm_rng_pkg::*;

  // Handshake: a word moves on any rising edge where rnd_valid & rnd_ready; while
  // rnd_valid is high and rnd_ready low, rnd_out is held unchanged; seed_load discards
  // a pending word even if it is being accepted in the same cycle.

  localparam rng_state_t INIT_STATE = (WARMUP_CYCLES == 0) ? RUN : WARMUP;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((WARMUP_CYCLES > 0) ? (WARMUP_CYCLES - 1) : 0);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [LFSR_W-1:0] lfsr_nxt;
  rnd_word_t         rnd_out_q, rnd_out_d;
  logic              rnd_valid_q, rnd_valid_d;
  logic              lockup_q, lockup_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  rng_state_t        state_q, state_d;
  logic              advance;

  lfsr25_step u_step (
    .state_i (lfsr_q),
    .next_o  (lfsr_nxt)
  );

  assign advance = enable & (~rnd_valid_q | rnd_ready);

  always_comb begin
    lfsr_d      = lfsr_q;
    rnd_out_d   = rnd_out_q;
    rnd_valid_d = rnd_valid_q;
    lockup_d    = lockup_q;
    cnt_d       = cnt_q;
    state_d     = state_q;

    if (seed_load) begin
      lfsr_d      = (seed == '0) ? DEFAULT_SEED : seed;
      rnd_valid_d = 1'b0;
      lockup_d    = 1'b0;
      cnt_d       = '0;
      state_d     = INIT_STATE;
    end else if (lfsr_q == '0) begin
      // An all-zero state would never leave zero; recover and flag it instead of stepping.
      lockup_d = 1'b1;
      lfsr_d   = DEFAULT_SEED;
      if (rnd_valid_q && rnd_ready) begin
        rnd_valid_d = 1'b0;
      end
    end else begin
      case (state_q)
        WARMUP: begin
          if (enable) begin
            lfsr_d = lfsr_nxt;
            if (cnt_q == CNT_LAST) begin
              state_d = RUN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        RUN: begin
          if (advance) begin
            lfsr_d      = lfsr_nxt;
            rnd_out_d   = rnd_word_t'(lfsr_nxt);
            rnd_valid_d = 1'b1;
          end else if (rnd_valid_q && rnd_ready) begin
            rnd_valid_d = 1'b0;
          end
        end
        default: begin
          state_d = INIT_STATE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lfsr_q      <= DEFAULT_SEED;
      rnd_out_q   <= '0;
      rnd_valid_q <= 1'b0;
      lockup_q    <= 1'b0;
      cnt_q       <= '0;
      state_q     <= INIT_STATE;
    end else begin
      lfsr_q      <= lfsr_d;
      rnd_out_q   <= rnd_out_d;
      rnd_valid_q <= rnd_valid_d;
      lockup_q    <= lockup_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
    end
  end

  assign rnd_out   = rnd_out_q;
  assign rnd_valid = rnd_valid_q;
  assign lockup    = lockup_q;
  assign warming   = (state_q == WARMUP);

endmodule

// File: tb/tb_lfsr25_gen.sv
// Bench for lfsr25_gen: one instance without warm-up, one with the default 32-step warm-up,
// both driven by the same inputs and checked every cycle against a behavioural model.
module tb_lfsr25_gen;

  localparam logic [24:0] DEF_SEED = 25'h1ACE5B1;

  // clock / reset
  logic Clk = 1'b0;
  logic Reset_n = 1'b1;
  always #5 Clk = ~Clk;

  logic        seed_load = 1'b0;
  logic [24:0] seed = '0;
  logic        enable = 1'b0;
  logic        rnd_ready = 1'b0;

  // index 0: WARMUP_CYCLES=0, index 1: default warm-up
  logic signed [24:0] d_out [2];
  logic               d_valid [2];
  logic               d_warm [2];
  logic               d_lock [2];

  lfsr25_gen #(.WARMUP_CYCLES(0), .CNT_W(6)) dut_n (
    .Clk(Clk), .Reset_n(Reset_n), .seed_load(seed_load), .seed(seed), .enable(enable),
    .rnd_out(d_out[0]), .rnd_valid(d_valid[0]), .rnd_ready(rnd_ready),
    .warming(d_warm[0]), .lockup(d_lock[0])
  );

  lfsr25_gen dut_w (
    .Clk(Clk), .Reset_n(Reset_n), .seed_load(seed_load), .seed(seed), .enable(enable),
    .rnd_out(d_out[1]), .rnd_valid(d_valid[1]), .rnd_ready(rnd_ready),
    .warming(d_warm[1]), .lockup(d_lock[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: plain shift arithmetic and a countdown of discarded steps
  function automatic logic [24:0] step_fn(input logic [24:0] s);
    logic [24:0] fb;
    fb = ((s >> 24) ^ (s >> 21)) & 25'd1;
    return ((s << 1) & 25'h1FFFFFF) | fb;
  endfunction

  logic [24:0] m_lfsr [2];
  logic [24:0] m_out [2];
  logic        m_valid [2];
  logic        m_lock [2];
  int          m_warm [2];
  logic        inject = 1'b0;

  function automatic int warm_cfg(input int i);
    return (i == 0) ? 0 : 32;
  endfunction

  function automatic logic [24:0] cur_state(input int i);
    return inject ? 25'd0 : m_lfsr[i];
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!Reset_n) begin
        m_lfsr[i]  <= DEF_SEED;
        m_out[i]   <= '0;
        m_valid[i] <= 1'b0;
        m_lock[i]  <= 1'b0;
        m_warm[i]  <= warm_cfg(i);
      end else if (seed_load) begin
        m_lfsr[i]  <= (seed == 0) ? DEF_SEED : seed;
        m_valid[i] <= 1'b0;
        m_lock[i]  <= 1'b0;
        m_warm[i]  <= warm_cfg(i);
      end else if (cur_state(i) == 0) begin
        m_lock[i] <= 1'b1;
        m_lfsr[i] <= DEF_SEED;
        if (m_valid[i] && rnd_ready) m_valid[i] <= 1'b0;
      end else if (m_warm[i] > 0) begin
        if (enable) begin
          m_lfsr[i] <= step_fn(m_lfsr[i]);
          m_warm[i] <= m_warm[i] - 1;
        end
      end else if (enable && (!m_valid[i] || rnd_ready)) begin
        m_lfsr[i]  <= step_fn(m_lfsr[i]);
        m_out[i]   <= step_fn(m_lfsr[i]);
        m_valid[i] <= 1'b1;
      end else if (m_valid[i] && rnd_ready) begin
        m_valid[i] <= 1'b0;
      end
    end
  end

  // scoreboard: every falling edge, every output of both instances
  always @(negedge Clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("out[%0d]", i), d_out[i], m_out[i]);
      check($sformatf("valid[%0d]", i), 25'(d_valid[i]), 25'(m_valid[i]));
      check($sformatf("warming[%0d]", i), 25'(d_warm[i]), 25'(m_warm[i] > 0));
      check($sformatf("lockup[%0d]", i), 25'(d_lock[i]), 25'(m_lock[i]));
      if (d_valid[i]) begin
        checks++;
        if (d_out[i] == 0) begin
          errors++;
          $display("FAIL nonzero_word[%0d] actual=%h expected=nonzero", i, d_out[i]);
        end
      end
    end
  end

  task automatic tick();
    @(negedge Clk);
  endtask

  logic [24:0] exp_q [$];
  int          pin_k [5] = '{1, 2, 3, 21, 22};
  logic [24:0] held;

  initial begin
    #1 Reset_n = 1'b0;
    tick();
    check("rst_out_w", d_out[1], 25'd0);
    check("rst_valid_w", 25'(d_valid[1]), 25'd0);
    check("rst_warming_w", 25'(d_warm[1]), 25'd1);
    check("rst_warming_n", 25'(d_warm[0]), 25'd0);
    check("rst_lockup_w", 25'(d_lock[1]), 25'd0);
    tick();
    Reset_n = 1'b1;
    tick();

    // sequence from seed 1 on the no-warm-up instance
    exp_q = '{25'h0000002, 25'h0000004, 25'h0000008, 25'h0200000, 25'h0400001};
    seed_load = 1'b1; seed = 25'd1; enable = 1'b1; rnd_ready = 1'b1;
    tick();
    seed_load = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      tick();
      check("seq_valid", 25'(d_valid[0]), 25'd1);
      for (int j = 0; j < 5; j++) begin
        if (pin_k[j] == k) check($sformatf("seq_word%0d", k), d_out[0], exp_q[j]);
      end
    end

    // backpressure: hold five cycles, then the very next step
    held = m_out[0];
    rnd_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold", d_out[0], held);
      check("bp_valid", 25'(d_valid[0]), 25'd1);
    end
    rnd_ready = 1'b1;
    tick();
    check("bp_next", d_out[0], step_fn(held));

    // warm-up from seed 1
    seed_load = 1'b1; seed = 25'd1;
    tick();
    seed_load = 1'b0;
    for (int k = 0; k < 32; k++) begin
      check("wu_warming", 25'(d_warm[1]), 25'd1);
      check("wu_valid", 25'(d_valid[1]), 25'd0);
      tick();
    end
    check("wu_done", 25'(d_warm[1]), 25'd0);
    tick();
    check("wu_first_valid", 25'(d_valid[1]), 25'd1);
    check("wu_first_word", d_out[1], 25'h0000900);

    // zero seed substitutes the default seed
    seed_load = 1'b1; seed = 25'd0;
    tick();
    seed_load = 1'b0;
    tick();
    check("zero_seed_word", d_out[0], 25'h159CB62);
    check("zero_seed_lockup", 25'(d_lock[0]), 25'd0);

    // seed_load wins over a simultaneous transfer
    for (int k = 0; k < 40; k++) tick();
    seed_load = 1'b1; seed = 25'($urandom_range(1, 32'h1FFFFFF));
    tick();
    seed_load = 1'b0;
    check("coll_valid_n", 25'(d_valid[0]), 25'd0);
    check("coll_valid_w", 25'(d_valid[1]), 25'd0);
    check("coll_warming_w", 25'(d_warm[1]), 25'd1);
    for (int k = 0; k < 45; k++) tick();

    // lock-up injection mid-RUN
    rnd_ready = 1'b0;
    tick();
    inject = 1'b1;
    force dut_n.lfsr_q = 25'd0;
    force dut_w.lfsr_q = 25'd0;
    tick();
    release dut_n.lfsr_q;
    release dut_w.lfsr_q;
    inject = 1'b0;
    check("lockup_set_n", 25'(d_lock[0]), 25'd1);
    check("lockup_set_w", 25'(d_lock[1]), 25'd1);
    tick();
    rnd_ready = 1'b1;
    tick();
    check("lockup_recover_n", d_out[0], 25'h159CB62);
    check("lockup_recover_w", d_out[1], 25'h159CB62);
    seed_load = 1'b1; seed = 25'($urandom_range(1, 32'h1FFFFFF));
    tick();
    seed_load = 1'b0;
    check("lockup_clear_n", 25'(d_lock[0]), 25'd0);
    check("lockup_clear_w", 25'(d_lock[1]), 25'd0);

    // randomized soak with backpressure, enable gaps and occasional reseeds
    for (int k = 0; k < 20000; k++) begin
      enable    = ($urandom_range(0, 7) != 0);
      rnd_ready = ($urandom_range(0, 3) != 0);
      seed_load = ($urandom_range(0, 499) == 0);
      seed      = ($urandom_range(0, 15) == 0) ? 25'd0 : 25'($urandom());
      tick();
    end
    seed_load = 1'b0;

    // asynchronous reset mid-stream
    enable = 1'b1; rnd_ready = 1'b1;
    for (int k = 0; k < 50; k++) tick();
    #2 Reset_n = 1'b0;
    #1;
    check("arst_out_w", d_out[1], 25'd0);
    check("arst_out_n", d_out[0], 25'd0);
    check("arst_valid_n", 25'(d_valid[0]), 25'd0);
    check("arst_warming_w", 25'(d_warm[1]), 25'd1);
    tick();
    tick();
    Reset_n = 1'b1;
    for (int k = 0; k < 60; k++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
